icache_line_fill: RTL and testbench
===================================

# icache_line_fill

Line-refill engine between the instruction cache and a word-wide, handshaked instruction memory. On a cache miss it fetches the eight-word aligned line containing the missing PC, one 32-bit word per memory transaction. It assembles the words into a line buffer and presents them as w0..w7 with a one-cycle `fill_valid` pulse, which drives the cache's `update`. The requester stalls fetch on `busy`.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 8: maximum issued-but-unreturned memory requests. Legal range is 1..8; 1 gives strictly serial access.

Ports:
- `CLK`  in  1  clock; all state changes on posedge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `miss_req`  in  1  level; cache requests a refill.
- `miss_addr`  in  32  PC of the missing instruction; sampled only at fill start.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  word address of the current request (byte address, bits [1:0]=0).
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid; responses return in request order.
- `mem_rdata`  in  32  read data.
- `w0`..`w7`  out  32 each  assembled line, word 0 at the lowest address.
- `line_addr`  out  32  line base address, `{miss_addr[31:5],5'b0}`.
- `fill_valid`  out  1  one-cycle pulse; w0..w7 and `line_addr` are complete.
- `busy`  out  1  fill in progress; requester holds the PC.

## Operation
- States:
  - IDLE: entered from reset and after DONE.
  - REQ: requests are being issued.
  - WAIT: all 8 requests issued, data still outstanding.
  - DONE: one cycle; `fill_valid`=1.
- IDLE → REQ when `miss_req`=1 at posedge. On that edge:
  - latch base = `{miss_addr[31:5],5'b0}` into `line_addr`;
  - clear `iss_cnt` and `rx_cnt` (4-bit each, range 0..8).
- REQ behaviour:
  - `mem_req`=1 while `iss_cnt`<8 and (`iss_cnt`−`rx_cnt`)<`MAX_OUTSTANDING`.
  - `mem_addr` = base + 4·`iss_cnt`.
  - `mem_req`&&`mem_gnt` increments `iss_cnt`.
  - When `iss_cnt` reaches 8, go to WAIT, or straight to DONE if `rx_cnt` also reaches 8 on the same edge.
- Any state except IDLE/DONE: `mem_rvalid` writes `mem_rdata` into word[`rx_cnt`] and increments `rx_cnt`. The 8th response moves the FSM to DONE.
- DONE → IDLE unconditionally. The requester must drop `miss_req` within the DONE cycle; the cache writes on negedge, so hit rises during DONE.
- `busy` = (state != IDLE), decoded from the state register.
- Address arithmetic:
  - mod 2^32, but base+28 never crosses a line boundary, so no wrap is possible.
  - `miss_addr[4:0]` is ignored; the fill always starts at word 0.

Boundary rules:
- `mem_rvalid` in IDLE or DONE, or when `rx_cnt`=8: ignored, no buffer write.
- `mem_gnt` while `mem_req`=0: ignored.
- `mem_gnt` and `mem_rvalid` in the same cycle: both counters update.
- `miss_addr` or `miss_req` changes mid-fill: ignored until the FSM is back in IDLE.
- `RST_N` low at any time, including mid-fill: immediately returns to IDLE with counters cleared.
  - In-flight memory responses arriving afterwards are ignored only while the FSM is in IDLE.
  - The memory must be reset together with this block.

## Timing
- Reset values:
  - state IDLE;
  - `mem_req`=0, `mem_addr`=0, `fill_valid`=0, `busy`=0;
  - `line_addr`=0, `w0`..`w7`=0;
  - `iss_cnt`=`rx_cnt`=0.
- `mem_req`, `mem_addr`, `fill_valid` and `busy` are decoded from registers only, never from current inputs.
- `mem_addr` is stable while `mem_req`=1 and `mem_gnt`=0.
- Minimum latency: `mem_gnt` always 1, 1-cycle read latency, `MAX_OUTSTANDING`=8.
  - miss sampled at edge E0;
  - requests in cycles 1..8;
  - `rvalid` in cycles 2..9;
  - `fill_valid` high in cycle 10.
- With `MAX_OUTSTANDING`=1 and 1-cycle latency, requests alternate with data, and `fill_valid` rises in cycle 17.
- w0..w7 are updated only by `rvalid` captures. They hold their value after DONE until the next fill overwrites them.
- Back-to-back fills: a new fill starts no earlier than the edge after DONE.

## Test plan
- Reset: assert `RST_N`=0 mid-simulation → all outputs 0 within the same cycle, asynchronously, with no clock edge needed.
- Single fill: `miss_addr`=0x00000124, `mem_gnt`=1, `mem_rdata`=addr with 1-cycle latency → `mem_addr` sequence 0x120,0x124…0x13C; `w0`=0x120…`w7`=0x13C; `line_addr`=0x120; `fill_valid` exactly one cycle, in cycle 10.
- Backpressure: `mem_gnt` high only on odd cycles → each address held until granted, no duplicate or skipped address; `MAX_OUTSTANDING`=1 → `iss_cnt`−`rx_cnt` never exceeds 1.
- Reset mid-fill: after 3 words returned, pulse `RST_N` low, then feed 2 stale `rvalid` in IDLE → no buffer change, no `fill_valid`; a following fill at 0xFFFFFFE4 yields `mem_addr` 0xFFFFFFE0…0xFFFFFFFC with no wrap.
- Protocol corners: change `miss_addr` mid-fill → line unaffected; zero-latency memory (`rvalid` in the same cycle as `gnt`) → correct line with `fill_valid` in cycle 9; two consecutive misses → second fill starts on the edge after DONE.

Source files
------------

// File: rtl/icache_line_fill_if.sv
// Word-wide handshaked instruction-memory read bus used by the line-refill engine.
interface icache_line_fill_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/icache_line_fill.sv
// Instruction-cache line refill: fetches an aligned 8-word line, one word per
// memory transaction, with up to MAX_OUTSTANDING requests in flight.
module icache_line_fill #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      miss_req,
  input  logic [31:0]               miss_addr,
  icache_line_fill_if.master        mem,
  output logic [31:0]               w0,
  output logic [31:0]               w1,
  output logic [31:0]               w2,
  output logic [31:0]               w3,
  output logic [31:0]               w4,
  output logic [31:0]               w5,
  output logic [31:0]               w6,
  output logic [31:0]               w7,
  output logic [31:0]               line_addr,
  output logic                      fill_valid,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  state_t            state, state_nxt;
  logic [3:0]        iss_cnt, rx_cnt, iss_nxt, rx_nxt;
  logic [7:0][31:0]  line;
  logic              req, iss_fire, rx_fire;
  logic              miss_off_unused;

  assign miss_off_unused = ^miss_addr[4:0];

  assign iss_fire = req && mem.mem_gnt;
  // Responses only count while a fill is live and the line is not yet full.
  assign rx_fire  = mem.mem_rvalid && (state == REQ || state == WAIT) && (rx_cnt != 4'd8);
  assign iss_nxt  = iss_cnt + {3'b000, iss_fire};
  assign rx_nxt   = rx_cnt + {3'b000, rx_fire};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_req) state_nxt = REQ;
      REQ: begin
        if (rx_nxt == 4'd8)       state_nxt = DONE;
        else if (iss_nxt == 4'd8) state_nxt = WAIT;
      end
      WAIT:    if (rx_nxt == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req        = (state == REQ) && (iss_cnt < 4'd8) && ((iss_cnt - rx_cnt) < MAX_OS);
    busy       = (state != IDLE);
    fill_valid = (state == DONE);
    mem.mem_req  = req;
    // Base is line-aligned, so the word offset is a plain concatenation.
    mem.mem_addr = req ? {line_addr[31:5], iss_cnt[2:0], 2'b00} : 32'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iss_cnt   <= 4'd0;
      rx_cnt    <= 4'd0;
      line_addr <= 32'h0;
      line      <= '0;
    end else if (state == IDLE && miss_req) begin
      line_addr <= {miss_addr[31:5], 5'b0};
      iss_cnt   <= 4'd0;
      rx_cnt    <= 4'd0;
    end else begin
      iss_cnt <= iss_nxt;
      rx_cnt  <= rx_nxt;
      if (rx_fire) line[rx_cnt[2:0]] <= mem.mem_rdata;
    end
  end

  assign w0 = line[0];
  assign w1 = line[1];
  assign w2 = line[2];
  assign w3 = line[3];
  assign w4 = line[4];
  assign w5 = line[5];
  assign w6 = line[6];
  assign w7 = line[7];
endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench: instance 0 (MAX_OUTSTANDING=8) and instance 1 (=1), each fed by
// a small memory model that returns the request address as data.
module tb_icache_line_fill;
  logic clk, rst_n;

  logic        miss_req  [2];
  logic [31:0] miss_addr [2];
  logic [31:0] w         [2][8];
  logic [31:0] line_addr [2];
  logic        fv        [2];
  logic        busy      [2];
  logic        r_req     [2];
  logic [31:0] r_addr    [2];
  logic        m_gnt     [2];
  logic        m_rv      [2];
  logic [31:0] m_rd      [2];

  // model configuration (written by the stimulus only)
  bit lat0 [2];
  bit gnt_odd [2];
  int stale_req [2];

  // model state / observations (written by the model only)
  int cyc [2], an [2], fv_n [2], fv_cyc [2], rv_n [2], os [2], osmax [2];
  int hold_err [2], stale_done [2];
  bit pend_v [2], hold_v [2];
  logic [31:0] pend_d [2], hold_a [2];
  logic [31:0] alog [2][256];

  int n_chk, n_pass;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    icache_line_fill_if bus ();
    icache_line_fill #(.MAX_OUTSTANDING(g == 0 ? 8 : 1)) u_dut (
      .CLK(clk), .RST_N(rst_n), .miss_req(miss_req[g]), .miss_addr(miss_addr[g]),
      .mem(bus),
      .w0(w[g][0]), .w1(w[g][1]), .w2(w[g][2]), .w3(w[g][3]),
      .w4(w[g][4]), .w5(w[g][5]), .w6(w[g][6]), .w7(w[g][7]),
      .line_addr(line_addr[g]), .fill_valid(fv[g]), .busy(busy[g])
    );
    assign bus.mem_gnt    = m_gnt[g];
    assign bus.mem_rvalid = m_rv[g];
    assign bus.mem_rdata  = m_rd[g];
    assign r_req[g]       = bus.mem_req;
    assign r_addr[g]      = bus.mem_addr;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Memory model: drives at negedge, DUT outputs are stable then.
  initial begin
    bit rv, gn;
    logic [31:0] rd;
    for (int g = 0; g < 2; g++) begin
      m_gnt[g] = 1'b0; m_rv[g] = 1'b0; m_rd[g] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        cyc[g]++;
        if (os[g] > osmax[g]) osmax[g] = os[g];
        rv = 1'b0; rd = 32'h0;
        if (stale_done[g] != stale_req[g]) begin
          rv = 1'b1; rd = 32'hDEAD_0000 | 32'(stale_done[g]); stale_done[g]++;
        end else if (pend_v[g]) begin
          rv = 1'b1; rd = pend_d[g];
        end
        pend_v[g] = 1'b0;
        gn = gnt_odd[g] ? cyc[g][0] : 1'b1;
        if (hold_v[g] && r_req[g] && r_addr[g] != hold_a[g]) hold_err[g]++;
        hold_v[g] = r_req[g] && !gn;
        hold_a[g] = r_addr[g];
        if (r_req[g] && gn) begin
          if (an[g] < 256) alog[g][an[g]] = r_addr[g];
          an[g]++;
          os[g]++;
          if (lat0[g]) begin rv = 1'b1; rd = r_addr[g]; end
          else begin pend_v[g] = 1'b1; pend_d[g] = r_addr[g]; end
        end
        if (rv && busy[g]) begin os[g]--; rv_n[g]++; end
        if (fv[g]) begin fv_n[g]++; fv_cyc[g] = cyc[g]; end
        m_gnt[g] = gn; m_rv[g] = rv; m_rd[g] = rd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_line(input int g, input logic [31:0] base, input int a0, input string tag);
    chk({tag, "_nreq"}, 32'(an[g] - a0), 32'd8);
    chk({tag, "_line_addr"}, line_addr[g], base);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), (a0 + i < 256) ? alog[g][a0 + i] : 32'hX, base + 32'(4 * i));
      chk($sformatf("%s_w%0d", tag, i), w[g][i], base + 32'(4 * i));
    end
  endtask

  // exp_rel < 0 skips the latency check (backpressured runs).
  task automatic fill(input int g, input logic [31:0] addr, input bit chg, input int exp_rel,
                      input string tag);
    int st, a0, f0;
    bit seen;
    a0 = an[g]; f0 = fv_n[g];
    miss_addr[g] = addr; miss_req[g] = 1'b1;
    st = cyc[g] + 1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (chg && k == 3) miss_addr[g] = 32'h5555_5554;
      if (fv[g]) seen = 1'b1;
    end
    miss_req[g] = 1'b0;
    chk({tag, "_done"}, 32'(seen), 32'd1);
    tick();
    if (exp_rel >= 0) chk({tag, "_fv_cycle"}, 32'(fv_cyc[g] - st), 32'(exp_rel));
    chk({tag, "_fv_pulses"}, 32'(fv_n[g] - f0), 32'd1);
    chk({tag, "_fv_low"}, 32'(fv[g]), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy[g]), 32'd0);
    check_line(g, addr & 32'hFFFF_FFE0, a0, tag);
  endtask

  initial begin
    int r0, f0;
    bit hit;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      miss_req[g] = 1'b0; miss_addr[g] = 32'h0;
    end
    #12;
    chk("rst_mem_req", 32'(r_req[0]), 32'd0);
    chk("rst_mem_addr", r_addr[0], 32'h0);
    chk("rst_fill_valid", 32'(fv[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_line_addr", line_addr[0], 32'h0);
    chk("rst_w7", w[0][7], 32'h0);
    rst_n = 1'b1;
    tick();

    fill(0, 32'h0000_0124, 1'b0, 10, "single");

    gnt_odd[0] = 1'b1;
    fill(0, 32'h0000_0200, 1'b0, -1, "bp8");
    chk("bp8_hold", 32'(hold_err[0]), 32'd0);
    gnt_odd[0] = 1'b0;

    fill(1, 32'h0000_0340, 1'b0, 17, "mo1");
    gnt_odd[1] = 1'b1;
    fill(1, 32'h0000_0388, 1'b0, -1, "mo1bp");
    chk("mo1_hold", 32'(hold_err[1]), 32'd0);
    chk("mo1_outstanding", 32'(osmax[1]), 32'd1);

    // reset in the middle of a fill, after three returned words
    r0 = rv_n[0]; hit = 1'b0;
    miss_addr[0] = 32'h0000_0404; miss_req[0] = 1'b1;
    for (int k = 0; k < 100 && !hit; k++) begin
      tick();
      if (rv_n[0] - r0 >= 3) hit = 1'b1;
    end
    chk("midrst_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_mem_req", 32'(r_req[0]), 32'd0);
    chk("midrst_mem_addr", r_addr[0], 32'h0);
    chk("midrst_line_addr", line_addr[0], 32'h0);
    chk("midrst_w0", w[0][0], 32'h0);
    miss_req[0] = 1'b0;
    #1;
    rst_n = 1'b1;
    f0 = fv_n[0];
    stale_req[0] = stale_req[0] + 2;
    repeat (5) tick();
    chk("stale_w0", w[0][0], 32'h0);
    chk("stale_w1", w[0][1], 32'h0);
    chk("stale_fv", 32'(fv_n[0] - f0), 32'd0);
    chk("stale_busy", 32'(busy[0]), 32'd0);

    fill(0, 32'hFFFF_FFE4, 1'b0, 10, "top");
    fill(0, 32'h0000_0800, 1'b1, 10, "addrchg");

    lat0[0] = 1'b1;
    fill(0, 32'h0000_0960, 1'b0, 9, "lat0");
    lat0[0] = 1'b0;

    fill(0, 32'h0000_0A00, 1'b0, 10, "b2b_a");
    fill(0, 32'h0000_0A3C, 1'b0, 10, "b2b_b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
